// File: rtl/redundant_shift_reg_pkg.sv
// ---------------------------------------------------------------------------
// redundant_shift_reg_pkg
//
// Shared definitions for the redundant (lockstep) shift register:
//   - ncopy_is_legal : elaboration-time check of the lane count
//   - majority3      : bitwise 2-of-3 vote, used when three lanes exist
//   - sat_all_ones   : all-ones value of a given width, used as the
//                      saturation point of the mismatch counter
//
// The vote and saturation helpers work on fixed maximum widths. Callers
// cast their operands up to these widths and cast the result back down.
// ---------------------------------------------------------------------------
package redundant_shift_reg_pkg;

    // Widest lane the vote helper handles.
    localparam int MAX_VOTE_W = 64;

    // Widest mismatch counter the saturation helper handles.
    localparam int MAX_CNTW = 32;

    // Two lanes give detection only; three lanes add bitwise correction.
    function automatic bit ncopy_is_legal(input int ncopy);
        return (ncopy == 2) || (ncopy == 3);
    endfunction

    // Each result bit is set when at least two of the three inputs agree on 1.
    function automatic logic [MAX_VOTE_W-1:0] majority3(
        input logic [MAX_VOTE_W-1:0] a,
        input logic [MAX_VOTE_W-1:0] b,
        input logic [MAX_VOTE_W-1:0] c
    );
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Low w bits set, remaining bits clear.
    function automatic logic [MAX_CNTW-1:0] sat_all_ones(input int w);
        logic [MAX_CNTW-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_CNTW; i++) begin
            if (i < w) begin
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_reg_lane.sv
// ---------------------------------------------------------------------------
// shift_reg_lane
//
// One lane of the redundant shift register: a DEPTH-stage, WIDTH-bit delay
// line that advances only when i_ce is high and otherwise holds.
//
// Ports:
//   i_clk    in   1      clock, rising edge
//   i_reset  in   1      asynchronous active-high reset, clears every stage
//   i_ce     in   1      shift enable
//   i_data   in   WIDTH  sample loaded into stage 0 on an enabled edge
//   o_data   out  WIDTH  final stage (sample from DEPTH enabled edges ago)
// ---------------------------------------------------------------------------
module shift_reg_lane #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_ce,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            stage_d[k] = stage_q[k];
        end
        if (i_ce) begin
            stage_d[0] = i_data;
            for (int k = 1; k < DEPTH; k++) begin
                stage_d[k] = stage_q[k-1];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    assign o_data = stage_q[DEPTH-1];

endmodule

// File: rtl/redundant_shift_reg.sv
// ---------------------------------------------------------------------------
// redundant_shift_reg
//
// Self-checking delay line. NCOPY identical shift lanes carry the same input
// stream; the last lane can be corrupted through i_inject to exercise the
// fault path. Lane outputs are compared every clock and a selected (NCOPY=2)
// or majority-voted (NCOPY=3) result is registered out, together with
// per-cycle mismatch, sticky error and a saturating mismatch counter.
//
// Ports:
//   i_clk      in   1      clock, rising edge
//   i_reset    in   1      asynchronous active-high reset
//   i_ce       in   1      shift enable for all lanes
//   i_data     in   WIDTH  input sample
//   i_inject   in   WIDTH  XOR fault mask applied to the input of lane NCOPY-1
//   i_clr_err  in   1      synchronous clear of o_err / o_err_cnt
//   o_data     out  WIDTH  lane 0 (NCOPY=2) or bitwise majority (NCOPY=3)
//   o_mismatch out  1      lanes' final stages differed on the previous clock
//   o_err      out  1      sticky mismatch flag
//   o_err_cnt  out  CNTW   saturating count of mismatch cycles
// ---------------------------------------------------------------------------
module redundant_shift_reg
    import redundant_shift_reg_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4,
    parameter int NCOPY = 2,
    parameter int CNTW  = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_ce,
    input  logic [WIDTH-1:0] i_data,
    input  logic [WIDTH-1:0] i_inject,
    input  logic             i_clr_err,
    output logic [WIDTH-1:0] o_data,
    output logic             o_mismatch,
    output logic             o_err,
    output logic [CNTW-1:0]  o_err_cnt
);

    // ------------------------------------------------------------------
    // Elaboration checks
    // ------------------------------------------------------------------
    if (!ncopy_is_legal(NCOPY)) begin : g_bad_ncopy
        $error("redundant_shift_reg: NCOPY must be 2 or 3");
    end
    if (DEPTH < 1) begin : g_bad_depth
        $error("redundant_shift_reg: DEPTH must be at least 1");
    end
    if (WIDTH < 1 || WIDTH > MAX_VOTE_W) begin : g_bad_width
        $error("redundant_shift_reg: WIDTH out of supported range");
    end
    if (CNTW < 1 || CNTW > MAX_CNTW) begin : g_bad_cntw
        $error("redundant_shift_reg: CNTW out of supported range");
    end

    localparam logic [CNTW-1:0] CNT_SAT = CNTW'(sat_all_ones(CNTW));

    // ------------------------------------------------------------------
    // Lanes
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] lane_in  [NCOPY];
    logic [WIDTH-1:0] lane_out [NCOPY];

    for (genvar j = 0; j < NCOPY; j++) begin : g_lane
        // Only the last lane sees the injection mask, so lane 0 always
        // carries the clean stream and a single corrupted lane can be voted
        // out when three lanes are present.
        if (j == NCOPY - 1) begin : g_inj
            assign lane_in[j] = i_data ^ i_inject;
        end else begin : g_clean
            assign lane_in[j] = i_data;
        end

        shift_reg_lane #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_lane (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_ce    (i_ce),
            .i_data  (lane_in[j]),
            .o_data  (lane_out[j])
        );
    end

    // ------------------------------------------------------------------
    // Vote / select
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] voted;

    if (NCOPY == 3) begin : g_vote3
        assign voted = WIDTH'(majority3(MAX_VOTE_W'(lane_out[0]),
                                        MAX_VOTE_W'(lane_out[1]),
                                        MAX_VOTE_W'(lane_out[2])));
    end else begin : g_sel0
        assign voted = lane_out[0];
    end

    // ------------------------------------------------------------------
    // Output and error registers
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] data_q, data_d;
    logic             mismatch_q, mismatch_d;
    logic             err_q, err_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;

    // Any lane disagreeing with lane 0 counts as a mismatch.
    always_comb begin
        mismatch_d = 1'b0;
        for (int j = 1; j < NCOPY; j++) begin
            if (lane_out[j] != lane_out[0]) begin
                mismatch_d = 1'b1;
            end
        end
    end

    // Error tracking works from the registered mismatch. A clear arriving in
    // the same cycle as a mismatch restarts the count at 1 rather than
    // dropping the event.
    always_comb begin
        data_d = voted;
        err_d  = err_q;
        cnt_d  = cnt_q;
        if (mismatch_q) begin
            err_d = 1'b1;
            if (i_clr_err) begin
                cnt_d = CNTW'(1);
            end else if (cnt_q != CNT_SAT) begin
                cnt_d = cnt_q + CNTW'(1);
            end
        end else if (i_clr_err) begin
            err_d = 1'b0;
            cnt_d = '0;
        end
    end

    // Output stage runs every clock, independent of i_ce.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            data_q     <= '0;
            mismatch_q <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            data_q     <= data_d;
            mismatch_q <= mismatch_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign o_data     = data_q;
    assign o_mismatch = mismatch_q;
    assign o_err      = err_q;
    assign o_err_cnt  = cnt_q;

endmodule

// File: tb/tb_redundant_shift_reg.sv
// ---------------------------------------------------------------------------
// tb_redundant_shift_reg
//
// Three instances share one stimulus stream:
//   dut2 : NCOPY=2, CNTW=8
//   dut3 : NCOPY=3, CNTW=8
//   dutc : NCOPY=2, CNTW=2 (counter saturates at 3)
// The reference model keeps the last DEPTH accepted (data, inject) pairs; a
// lane output is simply the sample accepted DEPTH ce-edges ago.
// ---------------------------------------------------------------------------
module tb_redundant_shift_reg;

  localparam int W = 8;
  localparam int D = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         i_reset;
  logic         i_ce;
  logic [W-1:0] i_data;
  logic [W-1:0] i_inject;
  logic         i_clr_err;

  logic [W-1:0] d2_data, d3_data, dc_data;
  logic         d2_mis, d3_mis, dc_mis;
  logic         d2_err, d3_err, dc_err;
  logic [7:0]   d2_cnt, d3_cnt;
  logic [1:0]   dc_cnt;

  redundant_shift_reg #(.WIDTH(W), .DEPTH(D), .NCOPY(2), .CNTW(8)) dut2 (
    .i_clk(clk), .i_reset(i_reset), .i_ce(i_ce), .i_data(i_data),
    .i_inject(i_inject), .i_clr_err(i_clr_err), .o_data(d2_data),
    .o_mismatch(d2_mis), .o_err(d2_err), .o_err_cnt(d2_cnt)
  );

  redundant_shift_reg #(.WIDTH(W), .DEPTH(D), .NCOPY(3), .CNTW(8)) dut3 (
    .i_clk(clk), .i_reset(i_reset), .i_ce(i_ce), .i_data(i_data),
    .i_inject(i_inject), .i_clr_err(i_clr_err), .o_data(d3_data),
    .o_mismatch(d3_mis), .o_err(d3_err), .o_err_cnt(d3_cnt)
  );

  redundant_shift_reg #(.WIDTH(W), .DEPTH(D), .NCOPY(2), .CNTW(2)) dutc (
    .i_clk(clk), .i_reset(i_reset), .i_ce(i_ce), .i_data(i_data),
    .i_inject(i_inject), .i_clr_err(i_clr_err), .o_data(dc_data),
    .o_mismatch(dc_mis), .o_err(dc_err), .o_err_cnt(dc_cnt)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] hist_d[$];
  logic [W-1:0] hist_i[$];

  logic [W-1:0] exp_data2, exp_data3;
  logic         exp_mis;
  logic         exp_err;
  int           exp_cnt;   // 8-bit counter, saturates at 255
  int           exp_cntc;  // 2-bit counter, saturates at 3

  function automatic logic [W-1:0] vote3(logic [W-1:0] a, logic [W-1:0] b,
                                         logic [W-1:0] c);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) begin
      r[i] = ((32'(a[i]) + 32'(b[i]) + 32'(c[i])) >= 2);
    end
    return r;
  endfunction

  task automatic model_reset();
    hist_d.delete();
    hist_i.delete();
    exp_data2 = '0;
    exp_data3 = '0;
    exp_mis   = 1'b0;
    exp_err   = 1'b0;
    exp_cnt   = 0;
    exp_cntc  = 0;
  endtask

  // Applies one rising edge worth of behaviour using the inputs present at it.
  task automatic model_edge();
    logic [W-1:0] clean, faulty;
    int n;
    if (i_reset) begin
      model_reset();
      return;
    end
    n = hist_d.size();
    clean  = (n >= D) ? hist_d[n-D] : '0;
    faulty = (n >= D) ? (hist_d[n-D] ^ hist_i[n-D]) : '0;
    if (exp_mis) begin
      exp_err = 1'b1;
      if (i_clr_err) begin
        exp_cnt  = 1;
        exp_cntc = 1;
      end else begin
        exp_cnt  = (exp_cnt  < 255) ? exp_cnt  + 1 : 255;
        exp_cntc = (exp_cntc < 3)   ? exp_cntc + 1 : 3;
      end
    end else if (i_clr_err) begin
      exp_err  = 1'b0;
      exp_cnt  = 0;
      exp_cntc = 0;
    end
    exp_data2 = clean;
    exp_data3 = vote3(clean, clean, faulty);
    exp_mis   = (faulty != clean);
    if (i_ce) begin
      hist_d.push_back(i_data);
      hist_i.push_back(i_inject);
      while (hist_d.size() > D) begin
        void'(hist_d.pop_front());
        void'(hist_i.pop_front());
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ph);
    chk({ph, "/dut2.data"}, 32'(d2_data), 32'(exp_data2));
    chk({ph, "/dut2.mis"},  32'(d2_mis),  32'(exp_mis));
    chk({ph, "/dut2.err"},  32'(d2_err),  32'(exp_err));
    chk({ph, "/dut2.cnt"},  32'(d2_cnt),  32'(exp_cnt));
    chk({ph, "/dut3.data"}, 32'(d3_data), 32'(exp_data3));
    chk({ph, "/dut3.mis"},  32'(d3_mis),  32'(exp_mis));
    chk({ph, "/dut3.err"},  32'(d3_err),  32'(exp_err));
    chk({ph, "/dut3.cnt"},  32'(d3_cnt),  32'(exp_cnt));
    chk({ph, "/dutc.data"}, 32'(dc_data), 32'(exp_data2));
    chk({ph, "/dutc.mis"},  32'(dc_mis),  32'(exp_mis));
    chk({ph, "/dutc.err"},  32'(dc_err),  32'(exp_err));
    chk({ph, "/dutc.cnt"},  32'(dc_cnt),  32'(exp_cntc));
  endtask

  // ---------------- driver tasks ----------------
  // One clock: inputs already set; model follows the edge, outputs are
  // sampled 1 time unit later.
  task automatic step(input string ph);
    @(posedge clk);
    model_edge();
    #1;
    check_all(ph);
  endtask

  task automatic drive(input logic ce, input logic [W-1:0] data,
                       input logic [W-1:0] inj, input logic clr);
    i_ce      = ce;
    i_data    = data;
    i_inject  = inj;
    i_clr_err = clr;
  endtask

  // ---------------- stimulus ----------------
  int pulses;
  int found;

  initial begin
    i_reset = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
    model_reset();
    #1;
    check_all("reset");
    step("reset_hold");
    step("reset_hold");
    i_reset = 1'b0;

    // Directed fill with ce held high.
    drive(1'b1, 8'h11, '0, 1'b0); step("fill");
    drive(1'b1, 8'h22, '0, 1'b0); step("fill");
    drive(1'b1, 8'h33, '0, 1'b0); step("fill");
    drive(1'b1, 8'h44, '0, 1'b0); step("fill");
    drive(1'b1, 8'h55, '0, 1'b0); step("fill");
    chk("first_out", 32'(d2_data), 32'h11);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'(8'h66 + 8'(i * 17)), '0, 1'b0);
      step("fill_seq");
    end

    // ce toggling: lanes hold on ce=0.
    for (int i = 0; i < 20; i++) begin
      drive(1'(i % 2 == 0), 8'($urandom_range(0, 255)), '0, 1'b0);
      step("ce_toggle");
    end

    // Single injection, two lanes.
    drive(1'b1, 8'($urandom_range(0, 255)), 8'h01, 1'b0);
    step("inj2");
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'($urandom_range(0, 255)), '0, 1'b0);
      step("inj2_tail");
      if (d2_mis) pulses++;
    end
    chk("inj2_pulses", 32'(pulses), 1);
    chk("inj2_err", 32'(d2_err), 1);
    chk("inj2_cnt", 32'(d2_cnt), 1);

    // Quiet clear, then single injection corrected by the vote.
    drive(1'b1, 8'h00, '0, 1'b1); step("clr_quiet");
    chk("clr_quiet_err", 32'(d3_err), 0);
    drive(1'b1, 8'h00, 8'h80, 1'b0); step("inj3");
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'h00, '0, 1'b0);
      step("inj3_tail");
      if (d3_mis) begin
        pulses++;
        chk("inj3_voted", 32'(d3_data), 32'h00);
      end
    end
    chk("inj3_pulses", 32'(pulses), 1);
    chk("inj3_cnt", 32'(d3_cnt), 1);

    // Continuous injection: small counter saturates at 3.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(1, 255)), 1'b0);
      step("sat_inj");
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 8'($urandom_range(0, 255)), '0, 1'b0);
      step("sat_tail");
    end
    chk("sat_cnt", 32'(dc_cnt), 3);

    // Clear during a quiet cycle.
    drive(1'b1, 8'($urandom_range(0, 255)), '0, 1'b1); step("clr2");
    chk("clr2_err", 32'(dc_err), 0);
    chk("clr2_cnt", 32'(dc_cnt), 0);

    // Clear coincident with a mismatch: the new event wins.
    drive(1'b1, 8'($urandom_range(0, 255)), 8'h3c, 1'b0); step("coin_inj");
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      drive(1'b1, 8'($urandom_range(0, 255)), '0, 1'b0);
      step("coin_wait");
      if (dc_mis) found = 1;
    end
    chk("coin_mis_seen", 32'(found), 1);
    drive(1'b1, 8'($urandom_range(0, 255)), '0, 1'b1); step("coin_clr");
    chk("coin_err", 32'(dc_err), 1);
    chk("coin_cnt", 32'(dc_cnt), 1);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)),
            ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'h00,
            1'($urandom_range(0, 15) == 0));
      step("random");
    end

    // Asynchronous reset between edges.
    #3;
    i_reset = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    step("async_rst_hold");
    i_reset = 1'b0;
    drive(1'b1, 8'hA5, '0, 1'b0); step("post_rst");
    for (int i = 0; i < D; i++) begin
      drive(1'b1, 8'($urandom_range(0, 255)), '0, 1'b0);
      step("post_rst");
    end
    chk("post_rst_first", 32'(d2_data), 32'hA5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
